// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction scheduler and its arbiter.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ADDR,
        ST_DATA,
        ST_HOLD
    } state_t;

    localparam int RD_FLAG_BIT = 7;
    localparam int WD_TIMEOUT  = 255;

    // The read flag owns bit 7, so a write address always goes out with bit 7 cleared.
    function automatic logic [7:0] make_add_byte(input logic [7:0] addr, input logic is_rd);
        logic [7:0] v;
        v = addr;
        v[RD_FLAG_BIT] = is_rd;
        return v;
    endfunction

endpackage

// File: rtl/spi_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the requester not served last.
module spi_rr_arb (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_grant
);

    logic r_rd_prio;

    always_comb begin
        o_grant = 2'b00;
        if (i_req[0] && (!i_req[1] || !r_rd_prio))
            o_grant = 2'b01;
        else if (i_req[1])
            o_grant = 2'b10;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_rd_prio <= 1'b0;
        else if (i_take)
            r_rd_prio <= o_grant[0];
    end

endmodule

// File: rtl/spi_txn_sched.sv
// SPI transaction scheduler: arbitrates write/read requesters, sequences chip select and byte bursts.
// Optional byte_done watchdog is compiled in by defining SPI_SCHED_TIMEOUT_EN.
module spi_txn_sched
    import spi_pkg::*;
#(
    parameter int RD_BYTES = 15,
    parameter int WR_BYTES = 1,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       m_clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] rd_addr,
    output logic       wr_grant,
    output logic       rd_grant,
    output logic [7:0] add_byte,
    output logic       spi_cs,
    output logic       mosi_sel,
    output logic       byte_start,
    input  logic       byte_done,
    output logic       busy,
    output logic       txn_done,
    output logic       txn_err
);

    localparam int MAX_BYTES = (RD_BYTES > WR_BYTES) ? RD_BYTES : WR_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);
    localparam int MAX_TMR   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TMR_W     = $clog2(MAX_TMR + 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TMR_W-1:0] r_tmr;
    logic             r_cs;
    logic             r_busy;
    logic             r_mosi;
    logic             r_start;
    logic             r_done;
    logic [7:0]       r_add;

    logic [1:0]       w_req;
    logic [1:0]       w_grant;
    logic             w_take;
    logic [CNT_W-1:0] w_last_idx;
    logic             w_data_last;
    logic             w_start_now;
    logic             w_byte_start;
    logic             w_wd_fire;

    assign w_req  = {rd_req, wr_req};
    assign w_take = (r_state == ST_IDLE) && (|w_req) && !rst;

    spi_rr_arb u_arb (
        .i_clk   (m_clk),
        .i_rst   (rst),
        .i_req   (w_req),
        .i_take  (w_take),
        .o_grant (w_grant)
    );

    // Grants and chained byte starts are combinational so they land in the same cycle as their cause.
    assign wr_grant     = w_take && w_grant[0];
    assign rd_grant     = w_take && w_grant[1];
    assign w_last_idx   = r_mosi ? CNT_W'(RD_BYTES - 1) : CNT_W'(WR_BYTES - 1);
    assign w_data_last  = (r_cnt == w_last_idx);
    assign w_start_now  = byte_done && ((r_state == ST_ADDR) ||
                                        ((r_state == ST_DATA) && !w_data_last));
    assign w_byte_start = r_start || w_start_now;

    assign byte_start = w_byte_start;
    assign spi_cs     = r_cs;
    assign busy       = r_busy;
    assign mosi_sel   = r_mosi;
    assign add_byte   = r_add;
    assign txn_done   = r_done;

`ifdef SPI_SCHED_TIMEOUT_EN
    logic [7:0] r_wd;
    logic       r_err;

    // r_wd holds the number of cycles elapsed since the most recent byte_start.
    assign w_wd_fire = ((r_state == ST_ADDR) || (r_state == ST_DATA)) && !byte_done &&
                       (r_wd == 8'(WD_TIMEOUT));

    always_ff @(posedge m_clk or posedge rst) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_wd_fire;
            if (w_byte_start)
                r_wd <= 8'd1;
            else if ((r_state == ST_ADDR) || (r_state == ST_DATA))
                r_wd <= r_wd + 8'd1;
            else
                r_wd <= '0;
        end
    end

    assign txn_err = r_err;
`else
    assign w_wd_fire = 1'b0;
    assign txn_err   = 1'b0;
`endif

    always_ff @(posedge m_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_mosi  <= 1'b0;
            r_add   <= '0;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state <= ST_SETUP;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_tmr   <= '0;
                        r_cnt   <= '0;
                        r_mosi  <= w_grant[1];
                        r_add   <= w_grant[1] ? make_add_byte(rd_addr, 1'b1)
                                              : make_add_byte(wr_addr, 1'b0);
                    end
                end
                ST_SETUP: begin
                    if (r_tmr == TMR_W'(CS_SETUP - 1)) begin
                        r_start <= 1'b1;
                        r_state <= ST_ADDR;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                    end
                end
                ST_DATA: begin
                    if (byte_done) begin
                        if (w_data_last) begin
                            r_state <= ST_HOLD;
                            r_tmr   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_tmr == TMR_W'(CS_HOLD - 1)) begin
                        r_state <= ST_IDLE;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
            // A watchdog expiry abandons the burst without a txn_done.
            if (w_wd_fire) begin
                r_state <= ST_IDLE;
                r_cs    <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_txn_sched.md
SPI_TXN_SCHED -- requirements
Module: spi_txn_sched

Interface
REQ-001 SHALL have parameter RD_BYTES, default 15, giving the read-burst length in bytes (15 x 8 = 120-bit readback).
REQ-002 SHALL have parameter WR_BYTES, default 1, giving the write-burst length in bytes.
REQ-003 SHALL have parameter CS_SETUP, default 2, giving m_clk cycles from spi_cs low to the first byte start.
REQ-004 SHALL have parameter CS_HOLD, default 2, giving m_clk cycles from the last byte done to spi_cs high.
REQ-005 SHALL have ports m_clk (in, 1, sole clock) and rst (in, 1, asynchronous active-high reset).
REQ-006 SHALL have ports wr_req (in, 1, write requester) and rd_req (in, 1, read requester), both level-held until granted.
REQ-007 SHALL have ports wr_addr and rd_addr (in, 8 each, register address for each requester).
REQ-008 SHALL have ports wr_grant and rd_grant (out, 1 each, one-cycle pulse on acceptance).
REQ-009 SHALL have port add_byte (out, 8, address byte of the active transaction, bit7 = 1 for read).
REQ-010 SHALL have port spi_cs (out, 1, active-low chip select).
REQ-011 SHALL have port mosi_sel (out, 1, 0 = write path, 1 = read path).
REQ-012 SHALL have port byte_start (out, 1, one-cycle pulse) and byte_done (in, 1, one-cycle pulse from the byte engine).
REQ-013 SHALL have ports busy (out, 1), txn_done (out, 1, one-cycle pulse) and txn_err (out, 1, one-cycle pulse).

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ADDR, DATA, HOLD.
REQ-015 IDLE: with any request present, SHALL grant in that cycle, latch the address and direction, drive spi_cs low, and enter SETUP on the next edge.
REQ-016 SHALL arbitrate round-robin: on a simultaneous wr_req and rd_req, grant the requester not served last; after reset, write wins.
REQ-017 SETUP SHALL count CS_SETUP cycles, then pulse byte_start and enter ADDR.
REQ-018 ADDR: on byte_done, SHALL pulse byte_start in the same cycle and enter DATA with the byte counter at 0.
REQ-019 DATA: each byte_done SHALL increment the counter; when the counter reaches N-1 (N = WR_BYTES or RD_BYTES), SHALL enter HOLD without a further byte_start, otherwise SHALL pulse byte_start.
REQ-020 HOLD SHALL count CS_HOLD cycles, then raise spi_cs, pulse txn_done, and return to IDLE; a new grant SHALL NOT occur before the next cycle, giving a minimum CS-high time of 1 cycle.
REQ-021 A byte_done in IDLE, SETUP or HOLD SHALL be ignored.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 A request deasserted mid-transaction SHALL NOT abort the transaction.
REQ-024 The byte counter SHALL be wide enough to hold max(RD_BYTES, WR_BYTES) and SHALL NOT wrap within a burst.

Reset
REQ-025 On rst SHALL go immediately to IDLE with spi_cs = 1 and all of the following at 0: grants, byte_start, busy, txn_done, txn_err, mosi_sel, add_byte, counters, and the round-robin pointer.
REQ-026 rst asserted mid-transaction SHALL abort with spi_cs high asynchronously and SHALL NOT pulse txn_done.

Configuration
REQ-027 With macro SPI_SCHED_TIMEOUT_EN defined, SHALL include a watchdog that is reloaded at each byte_start.
REQ-028 If byte_done is not received within 255 cycles, the watchdog SHALL pulse txn_err, raise spi_cs, and return to IDLE without txn_done.
REQ-029 Without SPI_SCHED_TIMEOUT_EN, SHALL have no watchdog, txn_err SHALL be tied to 0, and the FSM SHALL wait indefinitely for byte_done.

Structure
REQ-030 The state enum, the read-flag bit position (7) and the timeout constant (255) SHALL live in the shared package spi_pkg.
REQ-031 The round-robin arbiter SHALL be the sub-module spi_rr_arb (2 requests, last-served pointer, one-hot grant).

Verification
REQ-032 Single write: wr_req = 1 with wr_addr = 8'h12 -> wr_grant pulse, add_byte = 8'h12, mosi_sel = 0, 2 byte_start pulses, spi_cs low for CS_SETUP + 2 bytes + CS_HOLD, then 1 txn_done.
REQ-033 Single read: rd_addr = 8'h05 -> add_byte = 8'h85, mosi_sel = 1, 16 byte_start pulses, txn_done after the 16th byte_done + 2 cycles.
REQ-034 Simultaneous wr_req and rd_req after reset -> write served first, then read; with both held, grants alternate over 4 transactions.
REQ-035 rst pulsed during DATA byte 7 of a read -> spi_cs = 1 immediately, busy = 0, no txn_done; the next wr_req is served normally.
REQ-036 With SPI_SCHED_TIMEOUT_EN, byte_done withheld after the address byte -> txn_err pulse at cycle 255, spi_cs = 1, FSM in IDLE.
REQ-037 A stray byte_done pulse in IDLE and in HOLD -> no byte_start and no change to the counter or state.
